// File: rtl/mem_port_arbiter.sv
// Shares one single-ported synchronous RAM between a fetch port and a data port.
// Data wins arbitration; a wait counter forces a fetch grant after MAXWAIT data grants.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MAXWAIT = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          halt,

    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic          i_valid,
    output logic [DW-1:0] i_data,

    input  logic          d_req,
    input  logic          d_rw,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic          d_valid,
    output logic [DW-1:0] d_rdata,

    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

    localparam int             WCW      = (MAXWAIT > 0) ? $clog2(MAXWAIT + 1) : 1;
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAXWAIT);
    localparam int             STAGES   = 2;
    localparam logic           PORT_I   = 1'b0;
    localparam logic           PORT_D   = 1'b1;

    logic [WCW-1:0]    wait_cnt_reg;
    logic [WCW-1:0]    wait_cnt_next;
    logic              d_accept;
    logic              i_accept;
    logic              rd_accept;

    logic              m_en_reg;
    logic              m_we_reg;
    logic [AW-1:0]     m_addr_reg;
    logic [DW-1:0]     m_wdata_reg;

    logic [STAGES-1:0] tag_valid_reg;
    logic [STAGES-1:0] tag_port_reg;

    // Fetch is forced through only when it has already waited MAXWAIT data grants.
    always_comb begin
        i_ack = 1'b0;
        d_ack = 1'b0;
        if (!reset && !halt) begin
            if (d_req && !(i_req && (wait_cnt_reg == WAIT_MAX))) begin
                d_ack = 1'b1;
            end else if (i_req) begin
                i_ack = 1'b1;
            end
        end
    end

    assign d_accept  = d_req && d_ack;
    assign i_accept  = i_req && i_ack;
    assign rd_accept = i_accept || (d_accept && !d_rw);

    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (d_accept && i_req) begin
            if (wait_cnt_reg != WAIT_MAX) begin
                wait_cnt_next = wait_cnt_reg + 1'b1;
            end
        end else if (i_accept || !i_req) begin
            wait_cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_reg <= '0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // Address and write data hold their last value when idle; only the strobes drop.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_en_reg    <= 1'b0;
            m_we_reg    <= 1'b0;
            m_addr_reg  <= '0;
            m_wdata_reg <= '0;
        end else if (d_accept) begin
            m_en_reg    <= 1'b1;
            m_we_reg    <= d_rw;
            m_addr_reg  <= d_addr;
            m_wdata_reg <= d_wdata;
        end else if (i_accept) begin
            m_en_reg    <= 1'b1;
            m_we_reg    <= 1'b0;
            m_addr_reg  <= i_addr;
            m_wdata_reg <= '0;
        end else begin
            m_en_reg    <= 1'b0;
            m_we_reg    <= 1'b0;
        end
    end

    // Stage 0 lines up with the RAM strobe, the last stage with the RAM's registered output.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_valid_reg <= '0;
            tag_port_reg  <= '0;
        end else begin
            tag_valid_reg <= {tag_valid_reg[STAGES-2:0], rd_accept};
            tag_port_reg  <= {tag_port_reg[STAGES-2:0], d_accept ? PORT_D : PORT_I};
        end
    end

    assign m_en    = m_en_reg;
    assign m_we    = m_we_reg;
    assign m_addr  = m_addr_reg;
    assign m_wdata = m_wdata_reg;

    assign i_valid = tag_valid_reg[STAGES-1] && (tag_port_reg[STAGES-1] == PORT_I);
    assign d_valid = tag_valid_reg[STAGES-1] && (tag_port_reg[STAGES-1] == PORT_D);
    assign i_data  = m_rdata;
    assign d_rdata = m_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a grant/memory reference model queues the
// expected RAM strobes and read returns; a negedge monitor pops and compares them.
module tb_mem_port_arbiter;

    localparam int MAXWAIT = 3;

    logic        clk;
    logic        reset;
    logic        halt;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic        i_valid;
    logic [31:0] i_data;
    logic        d_req;
    logic        d_rw;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        m_en;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;

    mem_port_arbiter #(.AW(32), .DW(32), .MAXWAIT(MAXWAIT)) dut (
        .clk(clk), .reset(reset), .halt(halt),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_valid(i_valid), .i_data(i_data),
        .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_valid(d_valid), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic note_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event t=%0t", name, $time);
    endtask

    // Unwritten locations read back a pattern derived from the address.
    function automatic bit [31:0] def_val(input logic [31:0] a);
        return (a == 32'h1000) ? 32'hDEAD_BEEF : (a ^ 32'hC3A5_0F1E);
    endfunction

    // RAM behaviour: single port, registered read output.
    bit [31:0] ram [4096];
    bit        ram_written [4096];
    always @(posedge clk) begin
        if (m_en === 1'b1) begin
            if (m_we) begin
                ram[m_addr[13:2]]         <= m_wdata;
                ram_written[m_addr[13:2]] <= 1'b1;
            end else begin
                m_rdata <= ram_written[m_addr[13:2]] ? ram[m_addr[13:2]] : def_val(m_addr);
            end
        end
    end

    // Reference model state.
    typedef struct { int due; logic we; logic [31:0] addr; logic [31:0] wdata; } strobe_t;
    typedef struct { int due; logic [31:0] data; } rd_t;
    strobe_t   s_q[$];
    rd_t       iq[$];
    rd_t       dq[$];
    bit [31:0] ref_mem [4096];
    bit        ref_written [4096];
    int        cyc      = 0;
    int        consec   = 0;
    bit        m_i_acc  = 1'b0;
    bit        m_d_acc  = 1'b0;
    bit        mon_en   = 1'b0;

    // {fetch, data} grant expected from the current requests and the data-streak length.
    function automatic logic [1:0] exp_grant();
        if (reset || halt) return 2'b00;
        if (d_req && !(i_req && consec >= MAXWAIT)) return 2'b01;
        if (i_req) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_written[a[13:2]] ? ref_mem[a[13:2]] : def_val(a);
    endfunction

    always @(posedge clk) begin
        logic [1:0] g;
        strobe_t    s;
        rd_t        r;
        cyc++;
        m_i_acc = 1'b0;
        m_d_acc = 1'b0;
        if (reset) begin
            consec = 0;
            s_q.delete();
            iq.delete();
            dq.delete();
        end else begin
            g = exp_grant();
            if (g == 2'b01) begin
                m_d_acc = 1'b1;
                s = '{due: cyc, we: d_rw, addr: d_addr, wdata: d_wdata};
                s_q.push_back(s);
                if (d_rw) begin
                    ref_mem[d_addr[13:2]]     = d_wdata;
                    ref_written[d_addr[13:2]] = 1'b1;
                end else begin
                    r = '{due: cyc + 1, data: ref_read(d_addr)};
                    dq.push_back(r);
                end
            end else if (g == 2'b10) begin
                m_i_acc = 1'b1;
                s = '{due: cyc, we: 1'b0, addr: i_addr, wdata: 32'h0};
                s_q.push_back(s);
                r = '{due: cyc + 1, data: ref_read(i_addr)};
                iq.push_back(r);
            end
            if (m_d_acc && i_req) begin
                if (consec < MAXWAIT) consec++;
            end else if (m_i_acc || !i_req) begin
                consec = 0;
            end
        end
    end

    // Monitor: compares grants every cycle and pops expectations when they fall due.
    always @(negedge clk) begin
        strobe_t s;
        rd_t     r;
        if (mon_en) begin
            chk("ack", {i_ack, d_ack}, exp_grant());
            if (s_q.size() > 0 && s_q[0].due == cyc) begin
                s = s_q.pop_front();
                chk("m_en", m_en, 1);
                chk("m_we", m_we, s.we);
                chk("m_addr", m_addr, s.addr);
                chk("m_wdata", m_wdata, s.wdata);
            end else begin
                chk("m_en_idle", m_en, 0);
            end
            if (iq.size() > 0 && iq[0].due == cyc) begin
                r = iq.pop_front();
                chk("i_valid", i_valid, 1);
                chk("i_data", i_data, r.data);
                $display("txn fetch read  data=0x%08h expected=0x%08h cyc=%0d", i_data, r.data, cyc);
            end else begin
                chk("i_valid_idle", i_valid, 0);
            end
            if (dq.size() > 0 && dq[0].due == cyc) begin
                r = dq.pop_front();
                chk("d_valid", d_valid, 1);
                chk("d_rdata", d_rdata, r.data);
                $display("txn data  read  data=0x%08h expected=0x%08h cyc=%0d", d_rdata, r.data, cyc);
            end else begin
                chk("d_valid_idle", d_valid, 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_d_accept(input string name);
        for (int n = 0; n < 20; n++) begin
            step();
            if (m_d_acc) return;
        end
        note_fail(name);
    endtask

    logic [31:0] got;
    bit          seen;
    int          cnt;
    logic [1:0]  pat5 [3];

    initial begin
        reset = 1'b1; halt = 1'b0;
        i_req = 1'b1; i_addr = 32'h1004;
        d_req = 1'b1; d_rw = 1'b0; d_addr = 32'h100; d_wdata = 32'h0;

        // Reset held with both requests pending.
        for (int k = 0; k < 3; k++) begin
            step();
            mon_en = 1'b1;
            chk("reset_i_ack", i_ack, 0);
            chk("reset_d_ack", d_ack, 0);
            chk("reset_m_en", m_en, 0);
        end
        reset = 1'b0;
        #1;
        chk("first_grant", {i_ack, d_ack}, 2'b01);
        step();
        i_req = 1'b0; d_req = 1'b0;

        // Fetch only from a preloaded location.
        i_req = 1'b1; i_addr = 32'h1000;
        #1;
        chk("fetch_ack", i_ack, 1);
        step();
        i_req = 1'b0;
        chk("fetch_m_en", m_en, 1);
        chk("fetch_m_addr", m_addr, 32'h1000);
        seen = 1'b0; got = 32'h0;
        for (int k = 0; k < 4 && !seen; k++) begin
            step();
            if (i_valid === 1'b1) begin seen = 1'b1; got = i_data; end
        end
        chk("fetch_data", got, 32'hDEAD_BEEF);

        // Data write followed by read-back.
        d_req = 1'b1; d_rw = 1'b1; d_addr = 32'h104; d_wdata = 32'h1234_5678;
        wait_d_accept("write_accept");
        chk("write_m_we", m_we, 1);
        d_rw = 1'b0; d_wdata = 32'h0;
        wait_d_accept("read_accept");
        d_req = 1'b0;
        chk("read_m_we", m_we, 0);
        seen = 1'b0; got = 32'h0;
        for (int k = 0; k < 4 && !seen; k++) begin
            step();
            if (d_valid === 1'b1) begin seen = 1'b1; got = d_rdata; end
        end
        chk("readback_data", got, 32'h1234_5678);

        // Starvation: both requests held continuously.
        step();
        i_req = 1'b1; i_addr = 32'h1008;
        d_req = 1'b1; d_rw = 1'b0; d_addr = 32'h110;
        for (int k = 0; k < 12; k++) begin
            #1;
            chk("starve_grant", {i_ack, d_ack}, (k % 4 == 3) ? 2'b10 : 2'b01);
            step();
            if (m_d_acc) d_addr = 32'h100 + 4 * $urandom_range(0, 15);
            if (m_i_acc) i_addr = 32'h1000 + 4 * $urandom_range(0, 7);
        end
        i_req = 1'b0; d_req = 1'b0;

        // Halt with a read in flight; the data streak count survives the halt.
        step();
        i_req = 1'b1; i_addr = 32'h100C;
        d_req = 1'b1; d_rw = 1'b0; d_addr = 32'h104;
        step();
        halt = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("halt_acks", {i_ack, d_ack}, 2'b00);
            step();
        end
        halt = 1'b0;
        pat5[0] = 2'b01; pat5[1] = 2'b01; pat5[2] = 2'b10;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("resume_grant", {i_ack, d_ack}, pat5[k]);
            step();
        end
        i_req = 1'b0; d_req = 1'b0;

        // Reset one cycle after a read accept drops that read.
        step();
        d_req = 1'b1; d_rw = 1'b0; d_addr = 32'h108;
        step();
        if (!m_d_acc) note_fail("drop_read_accept");
        reset = 1'b1; d_req = 1'b0;
        step();
        reset = 1'b0;
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            if (d_valid === 1'b1) cnt++;
            step();
        end
        chk("dropped_read_valids", cnt, 0);

        // Randomised traffic with occasional halt and reset.
        for (int n = 0; n < 800; n++) begin
            reset = ($urandom_range(0, 199) == 0);
            halt  = ($urandom_range(0, 9) == 0);
            if (!i_req || m_i_acc) begin
                i_req  = ($urandom_range(0, 3) != 0);
                i_addr = 32'h1000 + 4 * $urandom_range(0, 7);
            end
            if (!d_req || m_d_acc) begin
                d_req   = ($urandom_range(0, 3) != 0);
                d_rw    = ($urandom_range(0, 2) == 0);
                d_addr  = 32'h100 + 4 * $urandom_range(0, 15);
                d_wdata = $urandom;
            end
            step();
        end

        reset = 1'b0; halt = 1'b0; i_req = 1'b0; d_req = 1'b0;
        for (int k = 0; k < 6; k++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
